control_unit: RTL and testbench

Multi-cycle control sequencer that sits directly upstream of `datapath` and drives every one of its control strobes. Each instruction is fetched and decoded from the IR opcode (`ir[31:27]`), then a fixed per-class T-step sequence is stepped through. The block also owns the program-counter increment value fed to the PC register. It covers the non-branch ISA subset; branch and jump opcodes execute as NOP in this revision.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/ctrl_decode.sv | 66 ++++++
 rtl/control_unit.sv | 81 ++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states, strobe vector and opcode classification
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_RR, C_UN, C_IMM, C_MD, C_LDI, C_LD, C_ST,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } class_e;

  typedef struct packed {
    logic pci, pco, iri, iro, mari, maro, mdri, mdro;
    logic mem_read, mem_write, hii, hio, loi, loo;
    logic ryi, rzhi, rzli, rzho, rzlo, ipo, opi, csigno;
    logic gra, grb, grc, rin, rout, baout;
  } strobes_t;

  function automatic class_e op_class(input logic [4:0] op);
    case (op)
      OP_LD:   return C_LD;
      OP_LDI:  return C_LDI;
      OP_ST:   return C_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: return C_RR;
      OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
      OP_MUL, OP_DIV: return C_MD;
      OP_NEG, OP_NOT: return C_UN;
      OP_IN:   return C_IN;
      OP_OUT:  return C_OUT;
      OP_MFHI: return C_MFHI;
      OP_MFLO: return C_MFLO;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  // final execute step of each class; the sequencer returns to T0 after it
  function automatic state_e last_state(input class_e c);
    case (c)
      C_RR, C_IMM, C_LDI: return S_T5;
      C_UN:               return S_T4;
      C_MD:               return S_T6;
      C_LD, C_ST:         return S_T7;
      default:            return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from sequencer state and opcode to datapath strobes
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_e     state,
  input  logic [4:0] op,
  input  logic       stop,
  output strobes_t   s
);

  class_e cls;

  assign cls = op_class(op);

  // fetch steps are opcode-independent; execute steps follow the opcode class
  always_comb begin
    s = '0;
    case (state)
      S_T0: begin s.pco = !stop; s.mari = !stop; end
      S_T1: begin s.mem_read = 1'b1; s.mdri = 1'b1; s.pci = 1'b1; end
      S_T2: begin s.mdro = 1'b1; s.iri = 1'b1; end
      S_T3:
        case (cls)
          C_RR, C_IMM:       begin s.grb = 1'b1; s.rout = 1'b1; s.ryi = 1'b1; end
          C_LDI, C_LD, C_ST: begin s.grb = 1'b1; s.baout = 1'b1; s.ryi = 1'b1; end
          C_MD:              begin s.gra = 1'b1; s.rout = 1'b1; s.ryi = 1'b1; end
          C_UN:              begin s.grb = 1'b1; s.rout = 1'b1; s.rzli = 1'b1; end
          C_IN:              begin s.ipo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          C_OUT:             begin s.gra = 1'b1; s.rout = 1'b1; s.opi = 1'b1; end
          C_MFHI:            begin s.hio = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          C_MFLO:            begin s.loo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          default: ;
        endcase
      S_T4:
        case (cls)
          C_RR:                     begin s.grc = 1'b1; s.rout = 1'b1; s.rzli = 1'b1; end
          C_UN:                     begin s.rzlo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST: begin s.csigno = 1'b1; s.rzli = 1'b1; end
          C_MD: begin s.grb = 1'b1; s.rout = 1'b1; s.rzhi = 1'b1; s.rzli = 1'b1; end
          default: ;
        endcase
      S_T5:
        case (cls)
          C_RR, C_IMM, C_LDI: begin s.rzlo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          C_MD:               begin s.rzlo = 1'b1; s.loi = 1'b1; end
          C_LD, C_ST:         begin s.rzlo = 1'b1; s.mari = 1'b1; end
          default: ;
        endcase
      S_T6:
        case (cls)
          C_MD: begin s.rzho = 1'b1; s.hii = 1'b1; end
          C_LD: begin s.mem_read = 1'b1; s.mdri = 1'b1; end
          C_ST: begin s.gra = 1'b1; s.rout = 1'b1; s.mdri = 1'b1; end
          default: ;
        endcase
      S_T7:
        case (cls)
          C_LD: begin s.mdro = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          C_ST: s.mem_write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/execute sequencer and PC increment for the datapath
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic [31:0] pc_immediate,
  output logic        run,
  output logic        pci, pco, iri, iro,
  output logic        mari, maro, mdri, mdro,
  output logic        mem_read, mem_write,
  output logic        hii, hio, loi, loo,
  output logic        ryi, ryo, rzhi, rzli, rzho, rzlo, rzo,
  output logic        ipi, ipo, opi,
  output logic        csigno,
  output logic        gra, grb, grc, rin, rout, baout
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  strobes_t    s;
  class_e      cls;
  logic        unused_ir;

  assign cls          = op_class(ir[31:27]);
  assign unused_ir    = ^ir[26:0];
  assign pc_immediate = pc_q + 32'd1;
  assign run          = state_q != S_HALT;

  // step through fetch, then the class-specific execute steps; halt parks until clear
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = stop ? S_T0 : S_T1;
      S_T1:   begin state_d = S_T2; pc_d = pc_immediate; end
      S_T2:   state_d = S_T3;
      S_HALT: state_d = S_HALT;
      default:
        state_d = (cls == C_HALT)                ? S_HALT :
                  (state_q == last_state(cls))   ? S_T0   :
                  state_e'(state_q + 4'd1);
    endcase
  end

  // state and PC registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RST;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ctrl_decode u_decode (
    .state (state_q),
    .op    (ir[31:27]),
    .stop  (stop),
    .s     (s)
  );

  assign {pci, pco, iri, iro, mari, maro, mdri, mdro} =
         {s.pci, s.pco, s.iri, s.iro, s.mari, s.maro, s.mdri, s.mdro};
  assign {mem_read, mem_write, hii, hio, loi, loo} =
         {s.mem_read, s.mem_write, s.hii, s.hio, s.loi, s.loo};
  assign {ryi, rzhi, rzli, rzho, rzlo, ipo, opi, csigno} =
         {s.ryi, s.rzhi, s.rzli, s.rzho, s.rzlo, s.ipo, s.opi, s.csigno};
  assign {gra, grb, grc, rin, rout, baout} =
         {s.gra, s.grb, s.grc, s.rin, s.rout, s.baout};
  assign ryo = 1'b0;
  assign rzo = 1'b0;
  assign ipi = 1'b1;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table, hand sequences and randomized model checks for control_unit
module tb_control_unit;

  localparam logic [29:0] PCI = 30'd1 << 0,  PCO = 30'd1 << 1,  IRI = 30'd1 << 2,  IRO = 30'd1 << 3;
  localparam logic [29:0] MARI = 30'd1 << 4, MARO = 30'd1 << 5, MDRI = 30'd1 << 6, MDRO = 30'd1 << 7;
  localparam logic [29:0] MR = 30'd1 << 8,   MW = 30'd1 << 9,   HII = 30'd1 << 10, HIO = 30'd1 << 11;
  localparam logic [29:0] LOI = 30'd1 << 12, LOO = 30'd1 << 13, RYI = 30'd1 << 14, RYO = 30'd1 << 15;
  localparam logic [29:0] RZHI = 30'd1 << 16, RZLI = 30'd1 << 17, RZHO = 30'd1 << 18, RZLO = 30'd1 << 19;
  localparam logic [29:0] RZO = 30'd1 << 20, IPO = 30'd1 << 21, OPI = 30'd1 << 22, CSIGNO = 30'd1 << 23;
  localparam logic [29:0] GRA = 30'd1 << 24, GRB = 30'd1 << 25, GRC = 30'd1 << 26, RIN = 30'd1 << 27;
  localparam logic [29:0] ROUT = 30'd1 << 28, BAOUT = 30'd1 << 29;
  localparam logic [29:0] DRV = PCO | IRO | MARO | MDRO | HIO | LOO | RYO | RZHO | RZLO | RZO |
                                IPO | CSIGNO | ROUT | BAOUT;
  localparam logic [29:0] F0 = PCO | MARI, F1 = MR | MDRI | PCI, F2 = MDRO | IRI;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] pc_immediate, pc_imm_w;
  logic        run, run_w, ipi, ipi_w;
  wire  [29:0] obs, obs_w;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop),
    .pc_immediate(pc_immediate), .run(run),
    .pci(obs[0]), .pco(obs[1]), .iri(obs[2]), .iro(obs[3]),
    .mari(obs[4]), .maro(obs[5]), .mdri(obs[6]), .mdro(obs[7]),
    .mem_read(obs[8]), .mem_write(obs[9]),
    .hii(obs[10]), .hio(obs[11]), .loi(obs[12]), .loo(obs[13]),
    .ryi(obs[14]), .ryo(obs[15]), .rzhi(obs[16]), .rzli(obs[17]),
    .rzho(obs[18]), .rzlo(obs[19]), .rzo(obs[20]),
    .ipi(ipi), .ipo(obs[21]), .opi(obs[22]), .csigno(obs[23]),
    .gra(obs[24]), .grb(obs[25]), .grc(obs[26]), .rin(obs[27]),
    .rout(obs[28]), .baout(obs[29])
  );

  control_unit #(.PC_RESET(32'hFFFF_FFFF)) dut_wrap (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop),
    .pc_immediate(pc_imm_w), .run(run_w),
    .pci(obs_w[0]), .pco(obs_w[1]), .iri(obs_w[2]), .iro(obs_w[3]),
    .mari(obs_w[4]), .maro(obs_w[5]), .mdri(obs_w[6]), .mdro(obs_w[7]),
    .mem_read(obs_w[8]), .mem_write(obs_w[9]),
    .hii(obs_w[10]), .hio(obs_w[11]), .loi(obs_w[12]), .loo(obs_w[13]),
    .ryi(obs_w[14]), .ryo(obs_w[15]), .rzhi(obs_w[16]), .rzli(obs_w[17]),
    .rzho(obs_w[18]), .rzlo(obs_w[19]), .rzo(obs_w[20]),
    .ipi(ipi_w), .ipo(obs_w[21]), .opi(obs_w[22]), .csigno(obs_w[23]),
    .gra(obs_w[24]), .grb(obs_w[25]), .grc(obs_w[26]), .rin(obs_w[27]),
    .rout(obs_w[28]), .baout(obs_w[29])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int bus_viol = 0;

  // any cycle with two bus drivers or simultaneous read/write is recorded
  always @(negedge clock)
    if (!clear && ($countones(obs & DRV) > 1 || (obs[8] && obs[9]))) bus_viol++;

  typedef struct {
    logic [4:0]  op;
    int          len;
    logic [29:0] st [8];
  } vec_t;

  vec_t tbl [16];
  int   ntbl = 0;

  task automatic add_vec(input logic [4:0] op, input int len,
                         input logic [29:0] s3 = '0, input logic [29:0] s4 = '0,
                         input logic [29:0] s5 = '0, input logic [29:0] s6 = '0,
                         input logic [29:0] s7 = '0);
    tbl[ntbl].op = op;
    tbl[ntbl].len = len;
    tbl[ntbl].st[0] = F0; tbl[ntbl].st[1] = F1; tbl[ntbl].st[2] = F2;
    tbl[ntbl].st[3] = s3; tbl[ntbl].st[4] = s4; tbl[ntbl].st[5] = s5;
    tbl[ntbl].st[6] = s6; tbl[ntbl].st[7] = s7;
    ntbl++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_len(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 6;
    if (op == 5'd15 || op == 5'd16) return 7;
    if (op == 5'd17 || op == 5'd18) return 5;
    return 4;
  endfunction

  function automatic int exp_rin(input logic [4:0] op);
    return (op <= 5'd1 || (op >= 5'd3 && op <= 5'd14) || op == 5'd17 || op == 5'd18 ||
            op == 5'd22 || op == 5'd24 || op == 5'd25) ? 1 : 0;
  endfunction

  logic [31:0] pc_exp;
  logic [4:0]  op;
  int n, c_pci, c_mr, c_mw, c_rin, c_hl, bad;

  initial begin
    add_vec(5'd3,  6, GRB | ROUT | RYI, GRC | ROUT | RZLI, RZLO | GRA | RIN);
    add_vec(5'd8,  6, GRB | ROUT | RYI, GRC | ROUT | RZLI, RZLO | GRA | RIN);
    add_vec(5'd17, 5, GRB | ROUT | RZLI, RZLO | GRA | RIN);
    add_vec(5'd12, 6, GRB | ROUT | RYI, CSIGNO | RZLI, RZLO | GRA | RIN);
    add_vec(5'd15, 7, GRA | ROUT | RYI, GRB | ROUT | RZHI | RZLI, RZLO | LOI, RZHO | HII);
    add_vec(5'd1,  6, GRB | BAOUT | RYI, CSIGNO | RZLI, RZLO | GRA | RIN);
    add_vec(5'd0,  8, GRB | BAOUT | RYI, CSIGNO | RZLI, RZLO | MARI, MR | MDRI, MDRO | GRA | RIN);
    add_vec(5'd2,  8, GRB | BAOUT | RYI, CSIGNO | RZLI, RZLO | MARI, GRA | ROUT | MDRI, MW);
    add_vec(5'd22, 4, IPO | GRA | RIN);
    add_vec(5'd23, 4, GRA | ROUT | OPI);
    add_vec(5'd24, 4, HIO | GRA | RIN);
    add_vec(5'd25, 4, LOO | GRA | RIN);
    add_vec(5'd26, 4);
    add_vec(5'd19, 4);
    add_vec(5'd30, 4);

    step(); step();
    clear = 1'b0;
    chk("rst_strobes", 32'(obs), 32'h0);
    chk("rst_pc_imm", pc_immediate, 32'h1);
    chk("rst_run", 32'(run), 32'h1);
    chk("ipi_tied", 32'(ipi), 32'h1);
    chk("wrap_rst_pc_imm", pc_imm_w, 32'h0);
    step();
    pc_exp = 32'h0;

    for (int i = 0; i < ntbl; i++) begin
      chk($sformatf("tbl%0d_pc_imm", i), pc_immediate, pc_exp + 32'd1);
      ir = {tbl[i].op, 27'($urandom)};
      for (int s = 0; s < tbl[i].len; s++) begin
        chk($sformatf("tbl_op%0d_T%0d", tbl[i].op, s), 32'(obs), 32'(tbl[i].st[s]));
        if (i == 0 && s == 2) chk("wrap_pc_after_T1", pc_imm_w, 32'h1);
        step();
      end
      chk($sformatf("tbl_op%0d_back_T0", tbl[i].op), 32'(obs), 32'(F0));
      pc_exp++;
    end

    stop = 1'b1;
    #1 chk("stop_T0_strobes", 32'(obs), 32'h0);
    bad = 0;
    repeat (5) begin step(); if (obs !== '0 || pc_immediate !== pc_exp + 32'd1) bad++; end
    chk("stop_5_cycles", 32'(bad), 32'h0);
    stop = 1'b0;
    #1 chk("stop_release_T0", 32'(obs), 32'(F0));
    ir = {5'd26, 27'd0};
    c_pci = 0;
    repeat (4) begin c_pci += int'(obs[0]); step(); end
    chk("stop_release_pci_once", 32'(c_pci), 32'h1);
    chk("stop_release_back_T0", 32'(obs), 32'(F0));
    pc_exp++;

    for (int k = 0; k < 150; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      if ($urandom_range(0, 7) == 0) begin
        stop = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        chk("rand_stop_idle", 32'(obs), 32'h0);
        stop = 1'b0;
        #1;
      end
      chk("rand_pc_imm", pc_immediate, pc_exp + 32'd1);
      ir = {op, 27'($urandom)};
      n = 0; c_pci = 0; c_mr = 0; c_mw = 0; c_rin = 0; c_hl = 0;
      do begin
        c_pci += int'(obs[0]); c_mr += int'(obs[8]); c_mw += int'(obs[9]);
        c_rin += int'(obs[27]); c_hl += int'(obs[10]) + int'(obs[12]);
        step();
        n++;
      end while (!obs[1] && n < 20);
      chk($sformatf("rand_op%0d_len", op), 32'(n), 32'(exp_len(op)));
      chk($sformatf("rand_op%0d_pci", op), 32'(c_pci), 32'h1);
      chk($sformatf("rand_op%0d_mem_read", op), 32'(c_mr), (op == 5'd0) ? 32'd2 : 32'd1);
      chk($sformatf("rand_op%0d_mem_write", op), 32'(c_mw), (op == 5'd2) ? 32'd1 : 32'd0);
      chk($sformatf("rand_op%0d_rin", op), 32'(c_rin), 32'(exp_rin(op)));
      chk($sformatf("rand_op%0d_hilo", op), 32'(c_hl), (op == 5'd15 || op == 5'd16) ? 32'd2 : 32'd0);
      pc_exp++;
    end

    ir = {5'd0, 27'd0};
    repeat (6) step();
    chk("ld_T6_strobes", 32'(obs), 32'(MR | MDRI));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_mid_ld_strobes", 32'(obs), 32'h0);
    chk("clear_mid_ld_pc_imm", pc_immediate, 32'h1);
    step();
    chk("after_clear_T0", 32'(obs), 32'(F0));

    ir = {5'd27, 27'd0};
    repeat (4) step();
    chk("halt_run_low", 32'(run), 32'h0);
    bad = 0;
    repeat (20) begin step(); if (run !== 1'b0 || obs !== '0) bad++; end
    chk("halt_hold_20", 32'(bad), 32'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("halt_clear_run", 32'(run), 32'h1);
    chk("halt_clear_pc_imm", pc_immediate, 32'h1);
    chk("halt_clear_strobes", 32'(obs), 32'h0);

    chk("bus_drivers", 32'(bus_viol), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
